// File: rtl/gf_mult_serial_host.sv
// Host-side bit-serial driver for the serial GF multiplier: shifts operands out, collects the product.
// Optional transaction counter enabled by defining GF_HOST_TXN_COUNT_EN.
module gf_mult_serial_host #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    ser_a,
    output logic                    ser_b,
    output logic                    ser_frame,
    input  logic                    ser_res,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic [15:0]             txn_count
);

    localparam int CW = $clog2(2*DATA_WIDTH+1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_OUT = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_SHIFT_IN  = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [CW-1:0] OUT_LAST  = CW'(DATA_WIDTH-1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((LATENCY > 0) ? LATENCY-1 : 0);
    localparam logic [CW-1:0] IN_LAST   = CW'(2*DATA_WIDTH-1);
    // With zero latency the result bits follow the last operand bit directly.
    localparam logic [2:0] AFTER_OUT = (LATENCY == 0) ? S_SHIFT_IN : S_WAIT;

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = S_SHIFT_OUT;
                end
            end
            S_SHIFT_OUT: begin
                a_d = {a_q[DATA_WIDTH-2:0], 1'b0};
                b_d = {b_q[DATA_WIDTH-2:0], 1'b0};
                if (cnt_q == OUT_LAST) begin
                    state_d = AFTER_OUT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = '0;
                end
            end
            S_SHIFT_IN: begin
                res_d = {res_q[2*DATA_WIDTH-2:0], ser_res};
                if (cnt_q == IN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign ser_frame = (state_q == S_SHIFT_OUT);
    assign ser_a     = ser_frame & a_q[DATA_WIDTH-1];
    assign ser_b     = ser_frame & b_q[DATA_WIDTH-1];
    assign res_data  = res_q;

`ifdef GF_HOST_TXN_COUNT_EN
    logic [15:0] txn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            txn_q <= '0;
        end else if (res_valid && res_ready) begin
            txn_q <= txn_q + 16'd1;
        end
    end

    assign txn_count = txn_q;
`else
    assign txn_count = '0;
`endif

endmodule
